// File: rtl/debug_view.sv
// Debug probe viewer: one probe channel, selected by a debounced page button,
// is periodically snapshotted and shown as hex digits on seven-segment drives.
module debug_view #(
  parameter int NCH        = 4,
  parameter int DW         = 32,
  parameter int SAMPLE_DIV = 1250000,
  parameter int DEB_CYCLES = 65536,
  localparam int NDIG      = DW / 4,
  localparam int PW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH*DW-1:0]   probe,
  input  logic                page_btn,
  input  logic                freeze,
  output logic [7*NDIG-1:0]   led,
  output logic [PW-1:0]       page,
  output logic                changed
);

  localparam int SCW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DCW = $clog2(DEB_CYCLES + 1);

  logic           sync1, sync2;
  logic           deb_level;
  logic [DCW-1:0] deb_cnt;
  logic [1:0]     warm;
  logic           armed;
  logic           step;
  logic           force_snap;
  logic [SCW-1:0] samp_cnt;
  logic [DW-1:0]  snap;
  logic [DW-1:0]  sel;
  logic [PW-1:0]  next_page;
  logic           tc;
  logic           accept;

  assign sel       = probe[int'(page)*DW +: DW];
  assign tc        = (samp_cnt == SCW'(SAMPLE_DIV - 1));
  assign accept    = (sync2 != deb_level) && (deb_cnt == DCW'(DEB_CYCLES - 1));
  assign next_page = (page == PW'(NCH - 1)) ? '0 : page + 1'b1;

  // Stepping is armed only once the synchronised button has been seen
  // released after reset, so a press held through reset never steps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      deb_level  <= 1'b0;
      deb_cnt    <= '0;
      warm       <= '0;
      armed      <= 1'b0;
      step       <= 1'b0;
      force_snap <= 1'b0;
      samp_cnt   <= '0;
      page       <= '0;
      snap       <= '0;
      changed    <= 1'b0;
    end else begin
      sync1 <= page_btn;
      sync2 <= sync1;
      warm  <= {warm[0], 1'b1};

      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (accept) begin
        deb_cnt   <= '0;
        deb_level <= sync2;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end

      if (warm[1] && !sync2 && !deb_level) armed <= 1'b1;
      step       <= accept && sync2 && armed;
      force_snap <= step;

      if (step) begin
        samp_cnt <= '0;
        page     <= next_page;
      end else if (tc) begin
        samp_cnt <= '0;
      end else begin
        samp_cnt <= samp_cnt + 1'b1;
      end

      // A terminal count in the step cycle is dropped; the forced load
      // one cycle later is the only snapshot and reads the new channel.
      if (force_snap) begin
        snap    <= sel;
        changed <= 1'b0;
      end else if (tc && !step && !freeze) begin
        snap    <= sel;
        changed <= (sel != snap);
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    assign led[7*i +: 7] = seg7(snap[4*i +: 4]);
  end

endmodule
